// File: rtl/pblaze_io_ctrl.sv
// kcpsm6 port-bus I/O controller: output register, synchronised 2-bit inputs,
// change-event pending/overrun tracking and a maskable interrupt with ack handshake.
module pblaze_io_ctrl #(
   parameter logic [7:0] OUT_ID  = 8'h05,
   parameter logic [7:0] PEND_ID = 8'h04,
   parameter logic [7:0] MASK_ID = 8'h06,
   parameter logic [7:0] OVR_ID  = 8'h07
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] port_id,
   input  logic       write_strobe,
   input  logic       read_strobe,
   input  logic [7:0] out_port,
   output logic [7:0] in_port,
   output logic       interrupt,
   input  logic       interrupt_ack,
   input  logic [1:0] input_a,
   input  logic [1:0] input_b,
   input  logic [1:0] input_c,
   input  logic [1:0] input_d,
   output logic [7:0] out
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0][1:0] pins;
   logic [3:0][1:0] s1_q, s2_q, h_q;
   logic [3:0]      evt;
   logic [3:0]      pending_q, pending_d;
   logic [3:0]      overrun_q, overrun_d;
   logic [3:0]      mask_q, mask_d;
   logic [7:0]      out_q, out_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            int_q, int_d;
   logic [3:0]      pend_clr;
   logic            ovr_rd;
   logic            irq_cond;

   assign pins = {input_d, input_c, input_b, input_a};

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_evt
         assign evt[g] = (s2_q[g] != h_q[g]);
      end
   endgenerate

   assign pend_clr = (write_strobe && (port_id == PEND_ID)) ? out_port[3:0] : '0;
   assign ovr_rd   = read_strobe && (port_id == OVR_ID);
   assign irq_cond = |(pending_q & mask_q);

   // Set beats clear; an event racing a W1C of its own bit is not an overrun.
   always_comb begin
      pending_d = (pending_q & ~pend_clr) | evt;
      overrun_d = (ovr_rd ? 4'b0000 : overrun_q) | (evt & pending_q & ~pend_clr);
   end

   always_comb begin
      out_d  = out_q;
      mask_d = mask_q;
      if (write_strobe) begin
         if (port_id == OUT_ID)  out_d  = out_port;
         if (port_id == MASK_ID) mask_d = out_port[3:0];
      end
   end

   always_comb begin
      rdata_d = '0;
      case (port_id)
         8'h00:   rdata_d = {6'b0, s2_q[0]};
         8'h01:   rdata_d = {6'b0, s2_q[1]};
         8'h02:   rdata_d = {6'b0, s2_q[2]};
         8'h03:   rdata_d = {6'b0, s2_q[3]};
         PEND_ID: rdata_d = {4'b0, pending_q};
         MASK_ID: rdata_d = {4'b0, mask_q};
         OVR_ID:  rdata_d = {4'b0, overrun_q};
         default: rdata_d = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (irq_cond) state_d = ST_ASSERT;
         end
         ST_ASSERT: begin
            if (interrupt_ack)  state_d = ST_SERVICE;
            else if (!irq_cond) state_d = ST_IDLE;
         end
         ST_SERVICE: begin
            if (!irq_cond) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      int_d = (state_d == ST_ASSERT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         h_q       <= '0;
         pending_q <= '0;
         overrun_q <= '0;
         mask_q    <= '0;
         out_q     <= '0;
         rdata_q   <= '0;
         int_q     <= 1'b0;
         state_q   <= ST_IDLE;
      end else begin
         s1_q      <= pins;
         s2_q      <= s1_q;
         h_q       <= s2_q;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         mask_q    <= mask_d;
         out_q     <= out_d;
         rdata_q   <= rdata_d;
         int_q     <= int_d;
         state_q   <= state_d;
      end
   end

   assign in_port   = rdata_q;
   assign interrupt = int_q;
   assign out       = out_q;

endmodule

// File: tb/tb_pblaze_io_ctrl.sv
// Directed bench for pblaze_io_ctrl: vector table for the bus/IRQ flow,
// hand sequences for overrun, set/clear races, ASSERT drop and async reset.
module tb_pblaze_io_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] port_id;
   logic       write_strobe;
   logic       read_strobe;
   logic [7:0] out_port;
   logic [7:0] in_port;
   logic       interrupt;
   logic       interrupt_ack;
   logic [1:0] input_a, input_b, input_c, input_d;
   logic [7:0] out;

   int total;
   int bad;

   pblaze_io_ctrl #(
      .OUT_ID (8'h05),
      .PEND_ID(8'h04),
      .MASK_ID(8'h06),
      .OVR_ID (8'h07)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .port_id      (port_id),
      .write_strobe (write_strobe),
      .read_strobe  (read_strobe),
      .out_port     (out_port),
      .in_port      (in_port),
      .interrupt    (interrupt),
      .interrupt_ack(interrupt_ack),
      .input_a      (input_a),
      .input_b      (input_b),
      .input_c      (input_c),
      .input_d      (input_d),
      .out          (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic       rd;
      logic       ack;
      logic [7:0] pid;
      logic [7:0] dat;
      logic [7:0] pins;
      logic [7:0] e_out;
      logic [7:0] e_in;
      logic       e_irq;
   } vec_t;

   vec_t vt[24];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic wr, input logic rd, input logic [7:0] pid, input logic [7:0] dat);
      write_strobe = wr;
      read_strobe  = rd;
      port_id      = pid;
      out_port     = dat;
   endtask

   task automatic pins(input logic [7:0] p);
      {input_d, input_c, input_b, input_a} = p;
   endtask

   initial begin
      total = 0;
      bad   = 0;

      // pins packed as {d,c,b,a}
      vt[0]  = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h79, 8'h00, 8'h00, 1'b0};
      vt[1]  = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h79, 8'h00, 8'h00, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h79, 8'h00, 8'h00, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h79, 8'h00, 8'h0F, 1'b0};
      vt[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h79, 8'h00, 8'h01, 1'b0};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 8'h02, 8'h00, 8'h79, 8'h00, 8'h03, 1'b0};
      vt[6]  = '{1'b0, 1'b0, 1'b0, 8'h06, 8'h00, 8'h79, 8'h00, 8'h00, 1'b0};
      vt[7]  = '{1'b1, 1'b0, 1'b0, 8'h05, 8'hA5, 8'h79, 8'hA5, 8'h00, 1'b0};
      vt[8]  = '{1'b1, 1'b0, 1'b0, 8'h09, 8'h3C, 8'h79, 8'hA5, 8'h00, 1'b0};
      vt[9]  = '{1'b1, 1'b0, 1'b0, 8'h04, 8'h0F, 8'h79, 8'hA5, 8'h0F, 1'b0};
      vt[10] = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h79, 8'hA5, 8'h00, 1'b0};
      vt[11] = '{1'b1, 1'b0, 1'b0, 8'h06, 8'hF2, 8'h79, 8'hA5, 8'h00, 1'b0};
      vt[12] = '{1'b0, 1'b0, 1'b0, 8'h06, 8'h00, 8'h79, 8'hA5, 8'h02, 1'b0};
      vt[13] = '{1'b0, 1'b1, 1'b0, 8'h07, 8'h00, 8'h79, 8'hA5, 8'h00, 1'b0};
      vt[14] = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h75, 8'hA5, 8'h00, 1'b0};
      vt[15] = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h75, 8'hA5, 8'h00, 1'b0};
      vt[16] = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h75, 8'hA5, 8'h00, 1'b0};
      vt[17] = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h75, 8'hA5, 8'h02, 1'b1};
      vt[18] = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h75, 8'hA5, 8'h02, 1'b1};
      vt[19] = '{1'b0, 1'b0, 1'b1, 8'h04, 8'h00, 8'h75, 8'hA5, 8'h02, 1'b0};
      vt[20] = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h75, 8'hA5, 8'h02, 1'b0};
      vt[21] = '{1'b1, 1'b0, 1'b0, 8'h04, 8'h02, 8'h75, 8'hA5, 8'h02, 1'b0};
      vt[22] = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h75, 8'hA5, 8'h00, 1'b0};
      vt[23] = '{1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h75, 8'hA5, 8'h00, 1'b0};

      rst           = 1'b0;
      interrupt_ack = 1'b0;
      bus(1'b0, 1'b0, 8'h00, 8'h00);
      pins(8'h79);
      step();
      step();
      check("rst_out", out, 8'h00);
      check("rst_irq", {7'b0, interrupt}, 8'h00);
      check("rst_in_port", in_port, 8'h00);
      rst = 1'b1;

      for (int i = 0; i < 24; i++) begin
         bus(vt[i].wr, vt[i].rd, vt[i].pid, vt[i].dat);
         interrupt_ack = vt[i].ack;
         pins(vt[i].pins);
         step();
         check($sformatf("v%0d_out", i), out, vt[i].e_out);
         check($sformatf("v%0d_in_port", i), in_port, vt[i].e_in);
         check($sformatf("v%0d_irq", i), {7'b0, interrupt}, {7'b0, vt[i].e_irq});
      end
      interrupt_ack = 1'b0;

      // Overrun: two toggles of channel c with no clear in between.
      bus(1'b0, 1'b0, 8'h04, 8'h00);
      pins(8'h45);
      repeat (4) step();
      pins(8'h75);
      repeat (4) step();
      bus(1'b0, 1'b1, 8'h07, 8'h00);
      step();
      check("ovr_read", in_port, 8'h04);
      step();
      check("ovr_cleared", in_port, 8'h00);
      check("ovr_irq_masked", {7'b0, interrupt}, 8'h00);
      bus(1'b0, 1'b0, 8'h04, 8'h00);
      step();
      check("ovr_pending", in_port, 8'h04);
      bus(1'b1, 1'b0, 8'h04, 8'h04);
      step();
      bus(1'b0, 1'b0, 8'h04, 8'h00);
      step();
      check("ovr_pending_clr", in_port, 8'h00);

      // Event coincident with W1C on the same bit, pending initially clear.
      pins(8'h45);
      step();
      step();
      bus(1'b1, 1'b0, 8'h04, 8'h04);
      step();
      bus(1'b0, 1'b0, 8'h04, 8'h00);
      step();
      check("race_set_wins", in_port, 8'h04);
      bus(1'b0, 1'b0, 8'h07, 8'h00);
      step();
      check("race_no_ovr", in_port, 8'h00);

      // Same race with pending already set: still no overrun.
      pins(8'h75);
      step();
      step();
      bus(1'b1, 1'b0, 8'h04, 8'h04);
      step();
      bus(1'b0, 1'b0, 8'h04, 8'h00);
      step();
      check("race2_pending", in_port, 8'h04);
      bus(1'b0, 1'b0, 8'h07, 8'h00);
      step();
      check("race2_no_ovr", in_port, 8'h00);

      // Mask dropped while ASSERT: back to IDLE, then re-assert on unmask.
      bus(1'b1, 1'b0, 8'h06, 8'h04);
      step();
      bus(1'b0, 1'b0, 8'h04, 8'h00);
      step();
      check("drop_irq_on", {7'b0, interrupt}, 8'h01);
      bus(1'b1, 1'b0, 8'h06, 8'h00);
      step();
      check("drop_irq_hold", {7'b0, interrupt}, 8'h01);
      bus(1'b0, 1'b0, 8'h04, 8'h00);
      step();
      check("drop_irq_off", {7'b0, interrupt}, 8'h00);
      bus(1'b1, 1'b0, 8'h06, 8'h04);
      step();
      check("reassert_wait", {7'b0, interrupt}, 8'h00);
      bus(1'b0, 1'b0, 8'h04, 8'h00);
      step();
      check("reassert_irq", {7'b0, interrupt}, 8'h01);

      // Asynchronous reset while interrupt is asserted.
      #2;
      rst = 1'b0;
      #1;
      check("midrst_irq", {7'b0, interrupt}, 8'h00);
      check("midrst_out", out, 8'h00);
      check("midrst_in_port", in_port, 8'h00);
      step();
      rst = 1'b1;
      bus(1'b0, 1'b0, 8'h06, 8'h00);
      step();
      check("midrst_mask", in_port, 8'h00);
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("midrst_noirq%0d", i), {7'b0, interrupt}, 8'h00);
      end
      bus(1'b0, 1'b0, 8'h04, 8'h00);
      step();
      check("midrst_pending", in_port, 8'h0F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
